// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and sequencer for the single-port data memory.
// Two masters; one transaction every 3 cycles; out-of-range addresses are rejected.
module dmem_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT
  } state_t;

  // one extra bit so DEPTH == 2**ADDR_W still compares correctly
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH);

  state_t state, state_d;
  logic   sel, sel_d;
  logic   last_grant, last_grant_d;
  logic   err_q, err_d;
  logic   we_q, we_d;

  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_d;
  logic              rd_d, wr_d;
  logic              ack0_d, ack1_d;
  logic              err0_d, err1_d;
  logic [DATA_W-1:0] rdata0_d, rdata1_d;

  logic              pick;
  logic              p_we;
  logic [ADDR_W-1:0] p_addr;
  logic [DATA_W-1:0] p_wdata;
  logic              p_in;
  logic [DATA_W-1:0] rd_val;

  always_comb begin
    pick    = (m0_req & m1_req) ? ~last_grant : m1_req;
    p_we    = pick ? m1_we    : m0_we;
    p_addr  = pick ? m1_addr  : m0_addr;
    p_wdata = pick ? m1_wdata : m0_wdata;
    p_in    = {1'b0, p_addr} < LIMIT;
    rd_val  = err_q ? '0 : mem_rdata;
  end

  always_comb begin
    state_d      = state;
    sel_d        = sel;
    last_grant_d = last_grant;
    err_d        = err_q;
    we_d         = we_q;
    addr_d       = mem_addr;
    wdata_d      = mem_wdata;
    rd_d         = 1'b0;
    wr_d         = 1'b0;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    err0_d       = 1'b0;
    err1_d       = 1'b0;
    rdata0_d     = m0_rdata;
    rdata1_d     = m1_rdata;
    unique case (state)
      IDLE: begin
        if (m0_req | m1_req) begin
          sel_d        = pick;
          last_grant_d = pick;
          addr_d       = p_addr;
          wdata_d      = p_wdata;
          wr_d         = p_we & p_in;
          rd_d         = ~p_we & p_in;
          err_d        = ~p_in;
          we_d         = p_we;
          state_d      = ACCESS;
        end
      end
      ACCESS: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (sel) begin
          ack1_d = 1'b1;
          err1_d = err_q;
          if (!we_q) rdata1_d = rd_val;
        end else begin
          ack0_d = 1'b1;
          err0_d = err_q;
          if (!we_q) rdata0_d = rd_val;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      sel        <= 1'b0;
      last_grant <= 1'b1;
      err_q      <= 1'b0;
      we_q       <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      m0_ack     <= 1'b0;
      m1_ack     <= 1'b0;
      m0_err     <= 1'b0;
      m1_err     <= 1'b0;
      m0_rdata   <= '0;
      m1_rdata   <= '0;
    end else begin
      state      <= state_d;
      sel        <= sel_d;
      last_grant <= last_grant_d;
      err_q      <= err_d;
      we_q       <= we_d;
      mem_addr   <= addr_d;
      mem_wdata  <= wdata_d;
      mem_read   <= rd_d;
      mem_write  <= wr_d;
      m0_ack     <= ack0_d;
      m1_ack     <= ack1_d;
      m0_err     <= err0_d;
      m1_err     <= err1_d;
      m0_rdata   <= rdata0_d;
      m1_rdata   <= rdata1_d;
    end
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter and sequencer for the single-port `data_memory` word array (registered read, one-cycle latency). It accepts load/store transactions from master 0 (CPU MEM stage) and master 1 (loader/debug port) and grants them round-robin. It drives the memory strobes for exactly one cycle per transaction and returns read data with a one-cycle `ack` pulse. Addresses outside the array are rejected without touching memory.

## Interface
- `DATA_W`, 32, data word width
- `ADDR_W`, 32, word-address width
- `DEPTH`, 256, number of memory words; a valid address is `addr < DEPTH`

- `clk  in  1  rising-edge clock`
- `rst  in  1  reset, asynchronous, active-high`
- `m0_req, m1_req  in  1  transaction request; held, with its fields stable, until the matching ack`
- `m0_we, m1_we  in  1  1 = write, 0 = read`
- `m0_addr, m1_addr  in  ADDR_W  word address`
- `m0_wdata, m1_wdata  in  DATA_W  write data`
- `m0_ack, m1_ack  out  1  one-cycle completion pulse`
- `m0_rdata, m1_rdata  out  DATA_W  read result; valid while ack is high, held afterwards`
- `m0_err, m1_err  out  1  pulses together with ack when the address is out of range`
- `mem_addr  out  ADDR_W  to memory addr`
- `mem_read, mem_write  out  1  to memory strobes`
- `mem_wdata  out  DATA_W  to memory write_data`
- `mem_rdata  in  DATA_W  from memory read_data`

## Operation
- FSM states are IDLE, ACCESS and WAIT.
- **IDLE:**
  - If neither master requests, stay in IDLE.
  - Otherwise select a master. If only one requests, select it. If both request, select the master other than `last_grant`.
  - Register `sel`, set `last_grant <= sel` and register `mem_addr`/`mem_wdata` from the selected master.
  - Set `mem_write <= we & in_range` and `mem_read <= ~we & in_range`, where `in_range = (addr < DEPTH)`.
  - Latch `err_q <= ~in_range`, then go to ACCESS.
- **ACCESS:**
  - The strobes are high during this single cycle only.
  - Clear both strobes at the end of the cycle and go to WAIT.
- **WAIT:**
  - `mem_rdata` is now valid.
  - Register `msel_rdata <= in_range ? mem_rdata : 0` for reads. For writes, `rdata` is unchanged.
  - Pulse `msel_ack` and `msel_err <= err_q`, then go to IDLE.
- `mem_addr` and `mem_wdata` hold their last values between transactions.
- The unselected master's request stays pending; it is not cancelled.
- A request still high at the edge where ack is high is treated as a new transaction (back-to-back).
- **Fairness:** with both masters requesting continuously, grants alternate 0,1,0,1,…
- **Reset:**
  - Values on reset: state = IDLE, `last_grant` = 1 (so master 0 wins the first tie), `sel` = 0, `err_q` = 0.
  - All outputs go to 0: `ack`, `err`, `rdata`, `mem_*`.
- **Reset mid-transaction:** strobes drop immediately and the transaction is abandoned with no ack. A write already sampled by memory stays in memory.

## Timing
- Let edge T sample a request in IDLE.
- Cycle T→T+1 (ACCESS): strobes high. The memory performs the access at edge T+1.
- Edge T+2 (leaving WAIT): `ack`, `rdata` and `err` become valid and stay high for the cycle T+2→T+3.
- Edge T+3: IDLE arbitrates again.
- Latency is 3 edges from request sample to ack visible. Peak throughput is one transaction per 3 cycles.
- Reads and writes have identical timing. Out-of-range accesses also take the same 3 cycles, with no strobe.
- At most one of `m0_ack`/`m1_ack` is high in any cycle. `mem_read` and `mem_write` are never both high.

## Test plan
- Reset, then m0 reads address 5 (memory initialised `Mem[i]=i`) → `mem_read` high for exactly 1 cycle; `m0_ack` 3 edges later with `m0_rdata`=5 and `m0_err`=0.
- m1 writes 0xDEADBEEF to address 10, then m0 reads address 10 → `m1_ack` with `mem_write` seen for 1 cycle; then `m0_rdata`=0xDEADBEEF.
- m0 and m1 hold their requests continuously, reading addresses 1 and 2 → acks alternate m0,m1,m0,m1, each every 3 cycles; rdata is 1 and 2 respectively.
- m0 reads address 300 → no `mem_read`/`mem_write`; `m0_ack`=`m0_err`=1 at T+2 with `m0_rdata`=0. A following read of address 3 returns 3 with `err`=0.
- Assert `rst` during ACCESS of an m1 read → all outputs are 0 asynchronously and no ack appears. After release, simultaneous m0/m1 requests grant m0 first.
- m0 keeps `req` high through its ack with a new address → a second transaction starts at the ack edge, and the second ack comes 3 cycles after the first.
